sdram_port_arbiter: RTL

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter_pkg.sv | 28 ++
 rtl/sdram_port_arbiter_if.sv | 34 +++
 rtl/sdram_port_arbiter_rr_pick4.sv | 27 ++
 rtl/sdram_port_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and constants for the four-port SDRAM burst arbiter.
package sdram_arb_pkg;

  localparam int NUM_PORTS = 4;

  // Port indices: two write ports followed by two read ports.
  localparam logic [1:0] WR1 = 2'd0;
  localparam logic [1:0] WR2 = 2'd1;
  localparam logic [1:0] RD1 = 2'd2;
  localparam logic [1:0] RD2 = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    REFRESH = 2'd2
  } state_t;

  // Convert a one-hot port vector to its index; zero vector maps to 0.
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Port-facing bus of the SDRAM arbiter: FIFO levels, address windows,
// burst length, completion strobe in; grant/burst descriptor out.
interface sdram_port_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int LEN_W  = 9,
  parameter int USED_W = 10
);
  logic [NUM_PORTS*USED_W-1:0] iUSEDW;
  logic [NUM_PORTS*ADDR_W-1:0] iBASE;
  logic [NUM_PORTS*ADDR_W-1:0] iMAX;
  logic [LEN_W-1:0]            iLENGTH;
  logic [NUM_PORTS-1:0]        iLOAD;
  logic                        iDONE;
  logic                        oSTART;
  logic [NUM_PORTS-1:0]        oGRANT;
  logic                        oWRITE;
  logic [ADDR_W-1:0]           oADDR;
  logic [LEN_W-1:0]            oLEN;
  logic                        oREF_START;

  // Arbiter side.
  modport slave (
    input  iUSEDW, iBASE, iMAX, iLENGTH, iLOAD, iDONE,
    output oSTART, oGRANT, oWRITE, oADDR, oLEN, oREF_START
  );

  // Command-engine / FIFO side.
  modport master (
    output iUSEDW, iBASE, iMAX, iLENGTH, iLOAD, iDONE,
    input  oSTART, oGRANT, oWRITE, oADDR, oLEN, oREF_START
  );
endinterface

// File: rtl/sdram_port_arbiter_rr_pick4.sv
// Combinational four-way round-robin picker: searches from ptr_i+1 upward.
module rr_pick4
  import sdram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [1:0]           ptr_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic                 valid_o
);

  logic [1:0] idx;

  // First requester after the pointer wins; 2-bit add wraps mod 4.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 2'd0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = ptr_i + 2'(k);
      if (!valid_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Four-port SDRAM burst arbiter with per-port wrapping address counters.
// Optional periodic refresh is enabled by defining SDRAM_ARB_REFRESH_EN;
// without it oREF_START is tied low and the arbiter never enters REFRESH.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int LEN_W      = 9,
  parameter int USED_W     = 10,
  parameter int REF_PERIOD = 390
)
(
  input logic                 iCLK,
  input logic                 iRST,
  sdram_port_arbiter_if.slave bus
);

  localparam int CMP_W = (USED_W > LEN_W) ? USED_W : LEN_W;

  state_t                 state_q;
  logic [1:0]             ptr_q;
  logic                   start_q;
  logic [NUM_PORTS-1:0]   grant_q;
  logic                   write_q;
  logic [ADDR_W-1:0]      burst_addr_q;
  logic [LEN_W-1:0]       len_q;

  logic [NUM_PORTS-1:0]   req;
  logic [NUM_PORTS-1:0]   pick_grant;
  logic                   pick_valid;
  logic [1:0]             pick_idx;
  logic [NUM_PORTS-1:0]   bump;
  logic [ADDR_W-1:0]      addr_w [NUM_PORTS];

  // A completed burst advances only the port that owned it.
  assign bump = (state_q == BUSY && bus.iDONE) ? grant_q : '0;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    localparam bit IS_WR = (gi == int'(WR1)) || (gi == int'(WR2));

    logic [USED_W-1:0] used;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] lim;
    logic [ADDR_W:0]   sum;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    assign used = bus.iUSEDW[gi*USED_W +: USED_W];
    assign base = bus.iBASE[gi*ADDR_W +: ADDR_W];
    assign lim  = bus.iMAX[gi*ADDR_W +: ADDR_W];

    // Writers need a full burst buffered; readers need room for one.
    if (IS_WR) begin : g_wr
      assign req[gi] = CMP_W'(used) >= CMP_W'(bus.iLENGTH);
    end else begin : g_rd
      assign req[gi] = CMP_W'(used) <  CMP_W'(bus.iLENGTH);
    end

    // Sum is one bit wider so a carry out still compares against the limit.
    always_comb begin
      sum    = {1'b0, addr_q} + (ADDR_W+1)'(bus.iLENGTH);
      addr_d = (sum >= {1'b0, lim}) ? base : sum[ADDR_W-1:0];
    end

    // Address counter: reset and explicit reload take priority over advance.
    always_ff @(posedge iCLK) begin
      if (iRST)                  addr_q <= base;
      else if (bus.iLOAD[gi])    addr_q <= base;
      else if (bump[gi])         addr_q <= addr_d;
    end

    assign addr_w[gi] = addr_q;
  end

  rr_pick4 u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

  assign pick_idx = onehot_to_idx(pick_grant);

`ifdef SDRAM_ARB_REFRESH_EN
  localparam int TMR_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  logic [TMR_W-1:0] tmr_q;
  logic             pend_q;
  logic             ref_start_q;

  // Free-running refresh timer; a new wrap re-arms even as IDLE consumes.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      tmr_q  <= '0;
      pend_q <= 1'b0;
    end else if (tmr_q == TMR_W'(REF_PERIOD - 1)) begin
      tmr_q  <= '0;
      pend_q <= 1'b1;
    end else begin
      tmr_q <= tmr_q + TMR_W'(1);
      if (state_q == IDLE && pend_q) pend_q <= 1'b0;
    end
  end

  assign bus.oREF_START = ref_start_q;
`else
  assign bus.oREF_START = 1'b0;
`endif

  // Arbitration FSM with registered burst descriptor and one-cycle strobes.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= IDLE;
      ptr_q        <= 2'd3;
      start_q      <= 1'b0;
      grant_q      <= '0;
      write_q      <= 1'b0;
      burst_addr_q <= '0;
      len_q        <= '0;
`ifdef SDRAM_ARB_REFRESH_EN
      ref_start_q  <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
`ifdef SDRAM_ARB_REFRESH_EN
      ref_start_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
`ifdef SDRAM_ARB_REFRESH_EN
          if (pend_q) begin
            ref_start_q <= 1'b1;
            state_q     <= REFRESH;
          end else
`endif
          if (pick_valid) begin
            grant_q      <= pick_grant;
            write_q      <= (pick_idx == WR1) || (pick_idx == WR2);
            burst_addr_q <= addr_w[pick_idx];
            len_q        <= bus.iLENGTH;
            ptr_q        <= pick_idx;
            start_q      <= 1'b1;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (bus.iDONE) begin
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        REFRESH: begin
          if (bus.iDONE) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oSTART = start_q;
  assign bus.oGRANT = grant_q;
  assign bus.oWRITE = write_q;
  assign bus.oADDR  = burst_addr_q;
  assign bus.oLEN   = len_q;

endmodule
